id_ex_stage: RTL and testbench

Decode-to-execute pipeline stage of the five-stage RV32I core. It sits directly downstream of the register file. It captures the two read operands, immediate, PC and decoded control for the instruction in ID, and presents them to EX one cycle later. It also owns load-use hazard detection (stall plus bubble insertion), branch flush handling, EX-stage forwarding selects, and two saturating hazard counters for debug.

---
 rtl/pipe_pkg.sv | 23 ++
 rtl/id_ex_stage_forward_unit.sv | 25 ++
 rtl/id_ex_stage.sv | 115 +++++++++++
 tb/tb_id_ex_stage.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control bundle bit positions and forwarding selects.
package pipe_pkg;

  localparam int CTRL_W = 12;

  localparam int CTRL_REG_WRITE  = 11;
  localparam int CTRL_MEM_READ   = 10;
  localparam int CTRL_MEM_WRITE  = 9;
  localparam int CTRL_MEM_TO_REG = 8;
  localparam int CTRL_ALU_SRC    = 7;
  localparam int CTRL_BRANCH     = 6;
  localparam int CTRL_USES_RS1   = 5;
  localparam int CTRL_USES_RS2   = 4;
  localparam int CTRL_ALU_OP_MSB = 3;
  localparam int CTRL_ALU_OP_LSB = 0;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  typedef logic [CTRL_W-1:0] ctrl_t;

endpackage

// File: rtl/id_ex_stage_forward_unit.sv
// Operand forwarding select for one EX source register; EX/MEM beats MEM/WB.
module forward_unit
  import pipe_pkg::*;
(
  input  logic       ex_valid,
  input  logic [4:0] ex_rs,
  input  logic       mem_reg_write,
  input  logic [4:0] mem_rd,
  input  logic       wb_reg_write,
  input  logic [4:0] wb_rd,
  output logic [1:0] fwd_sel
);

  always_comb begin
    fwd_sel = FWD_REG;
    if (ex_valid) begin
      if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == ex_rs)) begin
        fwd_sel = FWD_MEM;
      end else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == ex_rs)) begin
        fwd_sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush bubbles, forwarding selects
// and saturating debug counters for bubbles and flushes.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              flush,
  input  logic              mem_reg_write,
  input  logic [4:0]        mem_rd,
  input  logic              wb_reg_write,
  input  logic [4:0]        wb_rd,
  output logic              stall,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [XLEN-1:0]   ex_imm,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [1:0]        forward_a,
  output logic [1:0]        forward_b,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic rs1_hit;
  logic rs2_hit;
  logic load_in_ex;

  assign load_in_ex = ex_valid && ex_ctrl[CTRL_MEM_READ] && (ex_rd != 5'd0);
  assign rs1_hit    = id_ctrl[CTRL_USES_RS1] && (id_rs1 == ex_rd);
  assign rs2_hit    = id_ctrl[CTRL_USES_RS2] && (id_rs2 == ex_rd);
  assign stall      = id_valid && load_in_ex && (rs1_hit || rs2_hit) && !flush;

  // Flush and stall both insert a bubble; data fields hold since EX ignores them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_ctrl     <= '0;
    end else if (flush || stall) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= '0;
    end else begin
      ex_valid    <= id_valid;
      ex_pc       <= id_pc;
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      ex_rd       <= id_rd;
      ex_rs1_data <= id_rs1_data;
      ex_rs2_data <= id_rs2_data;
      ex_imm      <= id_imm;
      ex_ctrl     <= id_valid ? id_ctrl : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      if (stall && (bubble_cnt != CNT_MAX)) begin
        bubble_cnt <= bubble_cnt + CNT_ONE;
      end
      if (flush && id_valid && (flush_cnt != CNT_MAX)) begin
        flush_cnt <= flush_cnt + CNT_ONE;
      end
    end
  end

  forward_unit u_fwd_a (
    .ex_valid      (ex_valid),
    .ex_rs         (ex_rs1),
    .mem_reg_write (mem_reg_write),
    .mem_rd        (mem_rd),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .fwd_sel       (forward_a)
  );

  forward_unit u_fwd_b (
    .ex_valid      (ex_valid),
    .ex_rs         (ex_rs2),
    .mem_reg_write (mem_reg_write),
    .mem_rd        (mem_rd),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .fwd_sel       (forward_b)
  );

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus randomized traffic against a
// transaction-level model of the ID/EX register, hazards and counters.
module tb_id_ex_stage;

  localparam int XLEN   = 32;
  localparam int CNT_W  = 8;
  localparam int CMAX   = (1 << CNT_W) - 1;
  localparam int CW     = 12;
  // control bundle order: reg_write, mem_read, mem_write, mem_to_reg, alu_src,
  // branch, uses_rs1, uses_rs2, alu_op[3:0]
  localparam int B_MEM_READ = 10;
  localparam int B_USES_RS1 = 5;
  localparam int B_USES_RS2 = 4;
  localparam logic [CW-1:0] C_LW  = 12'hDA0;
  localparam logic [CW-1:0] C_ADD = 12'h830;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic            id_valid;
  logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]      id_rs1, id_rs2, id_rd, mem_rd, wb_rd;
  logic [CW-1:0]   id_ctrl;
  logic            flush, mem_reg_write, wb_reg_write;
  logic            stall, ex_valid;
  logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]      ex_rs1, ex_rs2, ex_rd;
  logic [CW-1:0]   ex_ctrl;
  logic [1:0]      forward_a, forward_b;
  logic [CNT_W-1:0] bubble_cnt, flush_cnt;

  id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_ctrl(id_ctrl), .flush(flush), .mem_reg_write(mem_reg_write),
    .mem_rd(mem_rd), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
    .stall(stall), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1(ex_rs1),
    .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_rs1_data(ex_rs1_data),
    .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl),
    .forward_a(forward_a), .forward_b(forward_b),
    .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  int total = 0;
  int bad   = 0;

  // reference model: the instruction currently sitting in EX, plus event tallies
  logic            m_valid;
  logic [XLEN-1:0] m_pc, m_d1, m_d2, m_imm;
  logic [4:0]      m_rs1, m_rs2, m_rd;
  logic [CW-1:0]   m_ctrl;
  int              m_bub, m_fl;

  function automatic logic model_stall();
    logic is_load;
    logic dep;
    is_load = m_valid && m_ctrl[B_MEM_READ] && (m_rd != 5'd0);
    dep = (id_ctrl[B_USES_RS1] && id_rs1 == m_rd) || (id_ctrl[B_USES_RS2] && id_rs2 == m_rd);
    return id_valid && is_load && dep && !flush;
  endfunction

  function automatic logic [1:0] model_fwd(input logic [4:0] rs);
    if (!m_valid) return 2'b00;
    if (mem_reg_write && mem_rd != 5'd0 && mem_rd == rs) return 2'b10;
    if (wb_reg_write && wb_rd != 5'd0 && wb_rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [4:0] rnd_reg();
    case ($urandom_range(0, 3))
      0: return 5'd0;
      1: return 5'd5;
      2: return 5'd7;
      default: return 5'($urandom);
    endcase
  endfunction

  task automatic model_clear();
    m_valid = 1'b0; m_pc = '0; m_d1 = '0; m_d2 = '0; m_imm = '0;
    m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_ctrl = '0; m_bub = 0; m_fl = 0;
  endtask

  task automatic idle_inputs();
    id_valid = 1'b0; id_pc = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_rs1_data = '0; id_rs2_data = '0; id_imm = '0; id_ctrl = '0;
    flush = 1'b0; mem_reg_write = 1'b0; mem_rd = '0; wb_reg_write = 1'b0; wb_rd = '0;
  endtask

  task automatic set_id(input logic v, input logic [XLEN-1:0] pc, input logic [4:0] r1,
                        input logic [4:0] r2, input logic [4:0] rd,
                        input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d2,
                        input logic [XLEN-1:0] imm, input logic [CW-1:0] c);
    id_valid = v; id_pc = pc; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
    id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_ctrl = c;
  endtask

  // one rising edge; called just after a falling edge, returns at the next one
  task automatic tick();
    logic s;
    s = model_stall();
    @(posedge clk);
    if (s && m_bub < CMAX) m_bub++;
    if (flush && id_valid && m_fl < CMAX) m_fl++;
    if (flush || s) begin
      m_valid = 1'b0;
      m_ctrl  = '0;
    end else begin
      m_valid = id_valid; m_pc = id_pc; m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd;
      m_d1 = id_rs1_data; m_d2 = id_rs2_data; m_imm = id_imm;
      m_ctrl = id_valid ? id_ctrl : '0;
    end
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_clear();
    @(negedge clk);
    #1;
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", ex_valid); end
    total++; if (ex_ctrl !== '0) begin bad++; $display("FAIL reset_ctrl: got %h want 000", ex_ctrl); end
    total++; if ({ex_pc, ex_rs1_data, ex_rs2_data, ex_imm} !== '0) begin bad++; $display("FAIL reset_data: got %h want 0", {ex_pc, ex_rs1_data, ex_rs2_data, ex_imm}); end
    total++; if ({ex_rs1, ex_rs2, ex_rd} !== '0) begin bad++; $display("FAIL reset_regs: got %h want 0", {ex_rs1, ex_rs2, ex_rd}); end
    total++; if ({bubble_cnt, flush_cnt} !== '0) begin bad++; $display("FAIL reset_cnt: got %h want 0", {bubble_cnt, flush_cnt}); end
    total++; if ({stall, forward_a, forward_b} !== 5'b0) begin bad++; $display("FAIL reset_comb: got %b want 00000", {stall, forward_a, forward_b}); end
    rst_n = 1'b1;
  endtask

  task automatic test_capture();
    do_reset();
    set_id(1'b1, 32'h100, 5'd1, 5'd2, 5'd3, 32'h1234, 32'h5678, 32'hFFFF_FFF0, 12'h800);
    tick();
    total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL cap_valid: got %b want 1", ex_valid); end
    total++; if (ex_rs1_data !== 32'h1234) begin bad++; $display("FAIL cap_rs1_data: got %h want 00001234", ex_rs1_data); end
    total++; if (ex_imm !== 32'hFFFF_FFF0) begin bad++; $display("FAIL cap_imm: got %h want fffffff0", ex_imm); end
    total++; if ({ex_pc, ex_rs2_data} !== {32'h100, 32'h5678}) begin bad++; $display("FAIL cap_pc_rs2: got %h want 0000010000005678", {ex_pc, ex_rs2_data}); end
    total++; if (ex_ctrl !== 12'h800) begin bad++; $display("FAIL cap_ctrl: got %h want 800", ex_ctrl); end
    set_id(1'b0, 32'h104, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h3, 12'hFFF);
    tick();
    total++; if ({ex_valid, ex_ctrl} !== 13'h0) begin bad++; $display("FAIL cap_invalid: got %h want 0000", {ex_valid, ex_ctrl}); end
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(1'b1, 32'h200, 5'd2, 5'd0, 5'd5, 32'h0, 32'h0, 32'h4, C_LW);
    tick();
    set_id(1'b1, 32'h204, 5'd5, 5'd1, 5'd6, 32'hAA, 32'hBB, 32'h0, C_ADD);
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL lu_stall: got %b want 1", stall); end
    tick();
    total++; if ({ex_valid, ex_ctrl} !== 13'h0) begin bad++; $display("FAIL lu_bubble: got %h want 0000", {ex_valid, ex_ctrl}); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL lu_stall_drop: got %b want 0", stall); end
    tick();
    total++; if ({ex_valid, ex_rd, ex_ctrl} !== {1'b1, 5'd6, C_ADD}) begin bad++; $display("FAIL lu_recapture: got %h want %h", {ex_valid, ex_rd, ex_ctrl}, {1'b1, 5'd6, C_ADD}); end
    total++; if (bubble_cnt !== CNT_W'(1)) begin bad++; $display("FAIL lu_bubble_cnt: got %0d want 1", bubble_cnt); end
    set_id(1'b1, 32'h208, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, C_LW);
    tick();
    set_id(1'b1, 32'h20C, 5'd0, 5'd0, 5'd4, 32'h0, 32'h0, 32'h0, C_ADD);
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL lu_x0: got %b want 0", stall); end
  endtask

  task automatic test_forward();
    do_reset();
    set_id(1'b1, 32'h300, 5'd7, 5'd7, 5'd8, 32'h0, 32'h0, 32'h0, C_ADD);
    tick();
    mem_reg_write = 1'b1; mem_rd = 5'd7; wb_reg_write = 1'b1; wb_rd = 5'd7;
    #1;
    total++; if ({forward_a, forward_b} !== 4'b1010) begin bad++; $display("FAIL fwd_mem_wins: got %b want 1010", {forward_a, forward_b}); end
    mem_reg_write = 1'b0;
    #1;
    total++; if (forward_a !== 2'b01) begin bad++; $display("FAIL fwd_wb: got %b want 01", forward_a); end
    mem_reg_write = 1'b1; mem_rd = 5'd0; wb_rd = 5'd0;
    #1;
    total++; if ({forward_a, forward_b} !== 4'b0000) begin bad++; $display("FAIL fwd_x0: got %b want 0000", {forward_a, forward_b}); end
    mem_rd = 5'd7;
    set_id(1'b0, 32'h304, 5'd7, 5'd7, 5'd8, 32'h0, 32'h0, 32'h0, C_ADD);
    tick();
    total++; if ({forward_a, forward_b} !== 4'b0000) begin bad++; $display("FAIL fwd_invalid: got %b want 0000", {forward_a, forward_b}); end
  endtask

  task automatic test_flush_load_use();
    do_reset();
    set_id(1'b1, 32'h400, 5'd1, 5'd0, 5'd5, 32'h0, 32'h0, 32'h0, C_LW);
    tick();
    set_id(1'b1, 32'h404, 5'd3, 5'd5, 5'd6, 32'h0, 32'h0, 32'h0, C_ADD);
    flush = 1'b1;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL fl_stall: got %b want 0", stall); end
    tick();
    flush = 1'b0;
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL fl_valid: got %b want 0", ex_valid); end
    total++; if ({flush_cnt, bubble_cnt} !== {CNT_W'(1), CNT_W'(0)}) begin bad++; $display("FAIL fl_cnts: got flush=%0d bubble=%0d want 1/0", flush_cnt, bubble_cnt); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    set_id(1'b1, 32'h500, 5'd2, 5'd0, 5'd5, 32'h11, 32'h0, 32'h8, C_LW);
    tick();
    set_id(1'b1, 32'h504, 5'd5, 5'd1, 5'd6, 32'h0, 32'h0, 32'h0, C_ADD);
    mem_reg_write = 1'b1; mem_rd = 5'd2;
    #1;
    total++; if ({stall, forward_a} !== 3'b110) begin bad++; $display("FAIL rms_pre: got %b want 110", {stall, forward_a}); end
    rst_n = 1'b0;
    #1;
    total++; if ({stall, forward_a, forward_b} !== 5'b0) begin bad++; $display("FAIL rms_comb: got %b want 00000", {stall, forward_a, forward_b}); end
    total++; if ({ex_valid, ex_ctrl, ex_rd, ex_pc, ex_rs1_data, ex_imm} !== '0) begin bad++; $display("FAIL rms_regs: got %h want 0", {ex_valid, ex_ctrl, ex_rd, ex_pc, ex_rs1_data, ex_imm}); end
    model_clear();
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      set_id($urandom_range(0, 3) != 0, $urandom, rnd_reg(), rnd_reg(), rnd_reg(),
             $urandom, $urandom, $urandom, 12'($urandom));
      if ($urandom_range(0, 1) == 1) id_ctrl[B_MEM_READ] = 1'b1;
      flush = ($urandom_range(0, 7) == 0);
      mem_reg_write = 1'($urandom); mem_rd = rnd_reg();
      wb_reg_write = 1'($urandom); wb_rd = rnd_reg();
      #1;
      total++; if (stall !== model_stall()) begin bad++; $display("FAIL rnd_stall[%0d]: got %b want %b", i, stall, model_stall()); end
      total++; if (forward_a !== model_fwd(m_rs1)) begin bad++; $display("FAIL rnd_fwd_a[%0d]: got %b want %b", i, forward_a, model_fwd(m_rs1)); end
      total++; if (forward_b !== model_fwd(m_rs2)) begin bad++; $display("FAIL rnd_fwd_b[%0d]: got %b want %b", i, forward_b, model_fwd(m_rs2)); end
      tick();
      total++; if ({ex_valid, ex_ctrl} !== {m_valid, m_ctrl}) begin bad++; $display("FAIL rnd_vc[%0d]: got %h want %h", i, {ex_valid, ex_ctrl}, {m_valid, m_ctrl}); end
      total++; if ({bubble_cnt, flush_cnt} !== {CNT_W'(m_bub), CNT_W'(m_fl)}) begin bad++; $display("FAIL rnd_cnt[%0d]: got %0d/%0d want %0d/%0d", i, bubble_cnt, flush_cnt, m_bub, m_fl); end
      if (m_valid) begin
        total++; if ({ex_pc, ex_rs1, ex_rs2, ex_rd} !== {m_pc, m_rs1, m_rs2, m_rd}) begin bad++; $display("FAIL rnd_pcregs[%0d]: got %h want %h", i, {ex_pc, ex_rs1, ex_rs2, ex_rd}, {m_pc, m_rs1, m_rs2, m_rd}); end
        total++; if ({ex_rs1_data, ex_rs2_data, ex_imm} !== {m_d1, m_d2, m_imm}) begin bad++; $display("FAIL rnd_data[%0d]: got %h want %h", i, {ex_rs1_data, ex_rs2_data, ex_imm}, {m_d1, m_d2, m_imm}); end
      end
    end
    idle_inputs();
  endtask

  task automatic test_saturation();
    do_reset();
    set_id(1'b1, 32'h600, 5'd5, 5'd0, 5'd5, 32'h0, 32'h0, 32'h0, C_LW);
    for (int i = 0; i < 2 * (CMAX + 20); i++) tick();
    total++; if (bubble_cnt !== CNT_W'(CMAX)) begin bad++; $display("FAIL sat_bubble: got %0d want %0d", bubble_cnt, CMAX); end
    flush = 1'b1;
    for (int i = 0; i < CMAX + 10; i++) tick();
    flush = 1'b0;
    total++; if (flush_cnt !== CNT_W'(CMAX)) begin bad++; $display("FAIL sat_flush: got %0d want %0d", flush_cnt, CMAX); end
    total++; if (bubble_cnt !== CNT_W'(CMAX)) begin bad++; $display("FAIL sat_bubble_hold: got %0d want %0d", bubble_cnt, CMAX); end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_capture();
    test_load_use();
    test_forward();
    test_flush_load_use();
    test_reset_mid_stall();
    test_random();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
